ssd_scan_decoder: RTL
=====================

# ssd_scan_decoder

Receive-side counterpart of the board's multiplexed seven-segment driver: it watches the scanned anode and cathode lines and rebuilds the four displayed hex digits, decimal points and blank flags as stable registered values. It sits beside the top level and taps the same anode and cathode nets that drive the pins. It serves as an on-chip display monitor for score and debug cross-checking, and is reused as a bench monitor. It also flags illegal segment patterns, anode conflicts and digits that have stopped being refreshed.

## Interface
Parameters:
- SETTLE_CYCLES, 16 — consecutive stable cycles required before a digit is sampled (2..255).
- TIMEOUT_CYCLES, 1048576 — cycles without a refresh before a digit is declared off.

Ports:
- board_clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-high.
- an_n  in  4  anodes {An3,An2,An1,An0}, active low.
- cath_n  in  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active low.
- digit  out  16  recovered hex values, digit[4i+3:4i] for anode i.
- dp  out  4  recovered decimal point per digit, 1 = lit.
- blank  out  4  1 = digit off (timed out, or all seven segments dark).
- digit_valid  out  4  1 = last sample of this digit decoded to a legal hex pattern and has not timed out.
- frame_valid  out  1  one-cycle pulse when a scan frame completes.
- frame_mask  out  4  digits seen in the frame just completed; updated with frame_valid.
- code_err  out  1  one-cycle pulse when an illegal segment pattern is sampled.
- conflict_err  out  1  one-cycle pulse on entry to a multi-anode-active condition.

## Operation
- Input stage: an_n and cath_n are registered once (r_an, r_cath). All decisions use the registered copies.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: no anode active. If exactly one anode is active, go to SETTLE with cnt = 1. If more than one is active, pulse conflict_err and stay in IDLE.
  - SETTLE: if r_an and r_cath both equal the previous cycle's values, cnt increments. Otherwise:
    - one anode still active: cnt = 1 and stay in SETTLE;
    - no anode active: go to IDLE;
    - more than one active: pulse conflict_err and go to IDLE.
  - SETTLE sample: when cnt reaches SETTLE_CYCLES, sample the digit and go to HOLD.
  - HOLD: hold until r_an changes, then re-evaluate as in IDLE in that same cycle.
- Sampling of digit i:
  - Decode r_cath[7:1] (abcdefg) against the 16-entry hex table; dp[i] = ~r_cath[0].
  - Legal code: digit[i] = value, digit_valid[i] = 1, blank[i] = 0.
  - All segments dark (7'b1111111): blank[i] = 1, digit_valid[i] = 1, digit[i] unchanged.
  - Any other pattern: digit_valid[i] = 0, blank[i] = 0, digit[i] unchanged, pulse code_err.
  - In every case age[i] is cleared.
- Hex table (abcdefg, active low), used exactly:
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, B 1100000
  - C 0110001, D 1000010, E 0110000, F 0111000
- Timeout: each age[i] saturating counter increments every cycle it is not sampled. On reaching TIMEOUT_CYCLES: blank[i] = 1 and digit_valid[i] = 0. Permanently-off anodes therefore read as blank.
- Frame: seen is a 4-bit register.
  - Sampling digit i with seen[i] = 0: seen[i] is set.
  - Sampling digit i with seen[i] = 1: pulse frame_valid, frame_mask = seen, and seen is set to the one-hot of i.
- Simultaneous events: a sample and a timeout of the same digit in one cycle resolve in favour of the sample.

## Timing
- Reset values: digit = 0, dp = 0, blank = 4'hF, digit_valid = 0, frame_valid = 0, frame_mask = 0, code_err = 0, conflict_err = 0. FSM goes to IDLE, and seen, cnt and age are all cleared.
- Latency: outputs for a digit update on the (SETTLE_CYCLES + 2)th rising edge after the pins settle (1 input register, SETTLE_CYCLES count, 1 output register). frame_valid and code_err are pulsed in that same cycle.
- A digit shown for fewer than SETTLE_CYCLES + 1 cycles is never sampled.
- Reset asserted mid-SETTLE: no partial sample is produced; after release, sampling restarts from IDLE.
- The age counter saturates; it never wraps.

## Structure
- Shared package ssd_pkg: 16-entry segment pattern constants, SEG_BLANK, and the FSM state enum.
- One natural sub-module: ssd_seg_decode, combinational, 7-bit pattern in, hex value plus is_legal and is_blank out. The same decoder is reused by bench models.

## Test plan
- Reset release with idle inputs (an_n = 4'hF) -> blank = 4'hF, digit_valid = 0; no pulses for 1000 cycles.
- Scan An0 with "3" (0000110), then An3 with "F" (0111000), 64 cycles each, repeated -> digit[3:0] = 3, digit[15:12] = F, digit_valid = 4'b1001. frame_valid pulses at the second An0 sample with frame_mask = 4'b1001.
- With TIMEOUT_CYCLES = 256 and An1 never driven -> blank[1] = 1 after 256 cycles. Stop driving An3 -> blank[3] rises exactly 256 cycles after its last sample.
- Drive An2 with illegal pattern 1111110 -> code_err pulses once, digit_valid[2] = 0, digit[11:8] unchanged.
- Drive an_n = 4'b1100 -> conflict_err pulses once and no sample occurs. Glitch a cathode every 10 cycles with SETTLE_CYCLES = 16 -> no sample at all.
- Assert Reset 5 cycles into SETTLE -> all outputs return to reset values. After release, the next sample occurs SETTLE_CYCLES + 2 edges after stable input.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan decoder.
//   SEG_BLANK : abcdefg pattern with every segment dark (active low).
//   SEG_PAT   : hex digit -> abcdefg pattern, active low; index is the digit value.
//   ssd_state_e : scan FSM states.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [15:0][6:0] SEG_PAT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // D
    7'b0110001,  // C
    7'b1100000,  // B
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } ssd_state_e;

endpackage

// File: rtl/ssd_scan_decoder_if.sv
// Bundle of the tapped display nets and the recovered display state.
//   an_n, cath_n : scanned anode / cathode lines, active low (driven by master).
//   digit, dp, blank, digit_valid : recovered per-digit state (driven by slave).
//   frame_valid, frame_mask : frame completion pulse and digits seen in it.
//   code_err, conflict_err : illegal pattern / multi-anode pulses.
interface ssd_scan_decoder_if;

  logic [3:0]  an_n;
  logic [7:0]  cath_n;
  logic [15:0] digit;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic [3:0]  frame_mask;
  logic        code_err;
  logic        conflict_err;

  modport master (
    output an_n, cath_n,
    input  digit, dp, blank, digit_valid, frame_valid, frame_mask, code_err, conflict_err
  );

  modport slave (
    input  an_n, cath_n,
    output digit, dp, blank, digit_valid, frame_valid, frame_mask, code_err, conflict_err
  );

endinterface

// File: rtl/ssd_seg_decode.sv
// Combinational seven-segment pattern decoder.
//   seg_i      : abcdefg, active low.
//   val_o      : hex value of a legal pattern (0 otherwise).
//   is_legal_o : pattern matches one of the 16 hex glyphs.
//   is_blank_o : all seven segments dark.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] val_o,
  output logic       is_legal_o,
  output logic       is_blank_o
);

  always_comb begin
    val_o      = 4'd0;
    is_legal_o = 1'b0;
    // Glyphs are unique, so at most one entry matches.
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg_i == SEG_PAT[i]) begin
        val_o      = 4'(i);
        is_legal_o = 1'b1;
      end
    end
  end

  assign is_blank_o = (seg_i == SEG_BLANK);

endmodule

// File: rtl/ssd_scan_decoder.sv
// Monitor for the multiplexed seven-segment display: watches the scanned anode and
// cathode nets and rebuilds the four shown digits, decimal points and blank flags.
//   board_clk : system clock, rising edge.
//   Reset     : asynchronous, active high.
//   bus       : ssd_scan_decoder_if slave (pins in, recovered state and pulses out).
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                board_clk,
  input  logic                Reset,
  ssd_scan_decoder_if.slave   bus
);

  localparam int unsigned AgeW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(TIMEOUT_CYCLES);
  localparam logic [7:0] CntMax = 8'(SETTLE_CYCLES);

  ssd_state_e            state_q;
  logic [3:0]            r_an_q, prev_an_q;
  logic [7:0]            r_cath_q, prev_cath_q;
  logic [7:0]            cnt_q;
  logic [3:0][AgeW-1:0]  age_q;
  logic [3:0]            seen_q;
  logic [15:0]           digit_q;
  logic [3:0]            dp_q, blank_q, valid_q, frame_mask_q;
  logic                  frame_valid_q, code_err_q, conflict_err_q;

  logic [3:0] act, act_prev;
  logic       act_one, act_multi, prev_multi, stable, an_changed;
  logic [1:0] sel_idx;
  logic [3:0] dec_val;
  logic       dec_legal, dec_blank;

  assign act        = ~r_an_q;
  assign act_prev   = ~prev_an_q;
  assign act_multi  = (act & (act - 4'd1)) != 4'd0;
  assign act_one    = (act != 4'd0) && !act_multi;
  assign prev_multi = (act_prev & (act_prev - 4'd1)) != 4'd0;
  assign an_changed = (r_an_q != prev_an_q);
  assign stable     = !an_changed && (r_cath_q == prev_cath_q);

  always_comb begin
    sel_idx = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (act[i]) sel_idx = 2'(i);
    end
  end

  ssd_seg_decode u_dec (
    .seg_i      (r_cath_q[7:1]),
    .val_o      (dec_val),
    .is_legal_o (dec_legal),
    .is_blank_o (dec_blank)
  );

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= StIdle;
      r_an_q         <= 4'hF;
      prev_an_q      <= 4'hF;
      r_cath_q       <= 8'hFF;
      prev_cath_q    <= 8'hFF;
      cnt_q          <= 8'd0;
      age_q          <= '0;
      seen_q         <= 4'd0;
      digit_q        <= 16'd0;
      dp_q           <= 4'd0;
      blank_q        <= 4'hF;
      valid_q        <= 4'd0;
      frame_valid_q  <= 1'b0;
      frame_mask_q   <= 4'd0;
      code_err_q     <= 1'b0;
      conflict_err_q <= 1'b0;
    end else begin
      r_an_q         <= bus.an_n;
      r_cath_q       <= bus.cath_n;
      prev_an_q      <= r_an_q;
      prev_cath_q    <= r_cath_q;
      frame_valid_q  <= 1'b0;
      code_err_q     <= 1'b0;
      // Pulse only on the transition into a multi-anode condition.
      conflict_err_q <= act_multi && !prev_multi;

      for (int unsigned i = 0; i < 4; i++) begin
        if (age_q[i] != AgeMax) begin
          age_q[i] <= age_q[i] + 1'b1;
          if (age_q[i] == AgeMax - 1'b1) begin
            blank_q[i] <= 1'b1;
            valid_q[i] <= 1'b0;
          end
        end
      end

      unique case (state_q)
        StIdle: begin
          if (act_one) begin
            state_q <= StSettle;
            cnt_q   <= 8'd1;
          end
        end
        StSettle: begin
          if (stable) begin
            if (cnt_q == CntMax) begin
              state_q <= StHold;
              // Sample assignments follow the age loop so a sample beats a timeout.
              dp_q[sel_idx]  <= ~r_cath_q[0];
              age_q[sel_idx] <= '0;
              if (dec_legal) begin
                digit_q[{sel_idx, 2'b00} +: 4] <= dec_val;
                valid_q[sel_idx] <= 1'b1;
                blank_q[sel_idx] <= 1'b0;
              end else if (dec_blank) begin
                valid_q[sel_idx] <= 1'b1;
                blank_q[sel_idx] <= 1'b1;
              end else begin
                valid_q[sel_idx] <= 1'b0;
                blank_q[sel_idx] <= 1'b0;
                code_err_q       <= 1'b1;
              end
              if (seen_q[sel_idx]) begin
                frame_valid_q <= 1'b1;
                frame_mask_q  <= seen_q;
                seen_q        <= 4'd1 << sel_idx;
              end else begin
                seen_q[sel_idx] <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end else if (act_one) begin
            cnt_q <= 8'd1;
          end else begin
            state_q <= StIdle;
          end
        end
        StHold: begin
          if (an_changed) begin
            if (act_one) begin
              state_q <= StSettle;
              cnt_q   <= 8'd1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.digit        = digit_q;
  assign bus.dp           = dp_q;
  assign bus.blank        = blank_q;
  assign bus.digit_valid  = valid_q;
  assign bus.frame_valid  = frame_valid_q;
  assign bus.frame_mask   = frame_mask_q;
  assign bus.code_err     = code_err_q;
  assign bus.conflict_err = conflict_err_q;

endmodule
